bitstream_sequencer: RTL

- Scheduler/controller for a bank of N_CH bitstreamer channels, one per antenna element.
- Accepts a transmit job over a valid/ready handshake and latches it into shadow registers: per-channel data words, per-channel phase delays, repeat count and inter-frame gap.
- Sequences the bitstreamers through reset, start and run, then repeats the frame with the programmed gap.
- Reports progress and completion to the host-side control logic.

---
 rtl/bitstream_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bitstream_sequencer.sv
// Scheduler for a bank of bitstreamer channels: latches a transmit job, then
// sequences reset/start/run per frame with a programmable repeat count and gap.
module bitstream_sequencer #(
   parameter int N_CH    = 4,
   parameter int DATALEN = 64,
   parameter int CNTLEN  = 8,
   parameter int CLK_DIV = 32,
   parameter int GAPW    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [N_CH*DATALEN-1:0]   cfg_data,
   input  logic [N_CH*CNTLEN-1:0]    cfg_phase,
   input  logic [7:0]                cfg_repeat,
   input  logic [GAPW-1:0]           cfg_gap,
   input  logic                      abort,
   output logic [N_CH*DATALEN-1:0]   bs_datain,
   output logic [N_CH*CNTLEN-1:0]    bs_phase_delay,
   output logic                      bs_rst,
   output logic                      bs_start,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted,
   output logic [7:0]                rep_cnt
);

   localparam int RUN_BASE = DATALEN * CLK_DIV;
   localparam int RUN_CW   = $clog2(RUN_BASE + 2**CNTLEN + 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      RUN,
      GAP,
      DONE,
      ABORT
   } state_t;

   state_t                    state_q, state_d;
   logic [N_CH*DATALEN-1:0]   data_q, data_d;
   logic [N_CH*CNTLEN-1:0]    phase_q, phase_d;
   logic [CNTLEN-1:0]         max_phase_q, max_phase_d;
   logic [7:0]                reps_q, reps_d;
   logic [GAPW-1:0]           gap_q, gap_d;
   logic [7:0]                rep_cnt_q, rep_cnt_d;
   logic [RUN_CW-1:0]         run_cnt_q, run_cnt_d;
   logic [GAPW-1:0]           gap_cnt_q, gap_cnt_d;
   logic                      cfg_ready_q, cfg_ready_d;
   logic                      bs_rst_q, bs_rst_d;
   logic                      bs_start_q, bs_start_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      aborted_q, aborted_d;

   logic [CNTLEN-1:0]         cfg_max_phase;
   logic [RUN_CW-1:0]         run_last;
   logic [8:0]                rep_next;
   logic                      more_reps;

   // The run window must cover the slowest stream plus the largest phase offset.
   always_comb begin
      cfg_max_phase = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (cfg_phase[k*CNTLEN +: CNTLEN] > cfg_max_phase) begin
            cfg_max_phase = cfg_phase[k*CNTLEN +: CNTLEN];
         end
      end
   end

   assign run_last  = RUN_CW'(RUN_BASE) + RUN_CW'(max_phase_q);
   assign rep_next  = {1'b0, rep_cnt_q} + 9'd1;
   assign more_reps = rep_next < {1'b0, reps_q};

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      phase_d     = phase_q;
      max_phase_d = max_phase_q;
      reps_d      = reps_q;
      gap_d       = gap_q;
      rep_cnt_d   = rep_cnt_q;
      run_cnt_d   = run_cnt_q;
      gap_cnt_d   = gap_cnt_q;

      case (state_q)
         IDLE: begin
            if (cfg_valid && cfg_ready_q) begin
               data_d      = cfg_data;
               phase_d     = cfg_phase;
               max_phase_d = cfg_max_phase;
               gap_d       = cfg_gap;
               reps_d      = (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
               rep_cnt_d   = 8'd0;
               state_d     = ARM;
            end
         end
         ARM: begin
            state_d = abort ? ABORT : START;
         end
         START: begin
            run_cnt_d = '0;
            state_d   = abort ? ABORT : RUN;
         end
         RUN: begin
            // Abort wins over frame completion, so a frame cut on its last cycle is not counted.
            if (abort) begin
               state_d = ABORT;
            end else if (run_cnt_q == run_last) begin
               rep_cnt_d = rep_next[7:0];
               if (!more_reps) begin
                  state_d = DONE;
               end else if (gap_q == '0) begin
                  state_d = ARM;
               end else begin
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end
            end else begin
               run_cnt_d = run_cnt_q + RUN_CW'(1);
            end
         end
         GAP: begin
            if (abort) begin
               state_d = ABORT;
            end else if (gap_cnt_q + GAPW'(1) == gap_q) begin
               state_d = ARM;
            end else begin
               gap_cnt_d = gap_cnt_q + GAPW'(1);
            end
         end
         DONE:    state_d = IDLE;
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_comb begin
      cfg_ready_d = (state_d == IDLE);
      bs_rst_d    = (state_d == ARM) || (state_d == ABORT);
      bs_start_d  = (state_d == START);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      aborted_d   = (state_d == ABORT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         phase_q     <= '0;
         max_phase_q <= '0;
         reps_q      <= 8'd0;
         gap_q       <= '0;
         rep_cnt_q   <= 8'd0;
         run_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         cfg_ready_q <= 1'b0;
         bs_rst_q    <= 1'b1;
         bs_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         phase_q     <= phase_d;
         max_phase_q <= max_phase_d;
         reps_q      <= reps_d;
         gap_q       <= gap_d;
         rep_cnt_q   <= rep_cnt_d;
         run_cnt_q   <= run_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         cfg_ready_q <= cfg_ready_d;
         bs_rst_q    <= bs_rst_d;
         bs_start_q  <= bs_start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   assign cfg_ready      = cfg_ready_q;
   assign bs_datain      = data_q;
   assign bs_phase_delay = phase_q;
   assign bs_rst         = bs_rst_q;
   assign bs_start       = bs_start_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign rep_cnt        = rep_cnt_q;

endmodule
